// File: rtl/mips_pkg.sv
// mips_pkg: shared decode constants for the ID/EX control path.
//   - ALUControl encodings (ALU_*)
//   - opcode constants (OP_*) taken from InstrD[31:26]
//   - R-type funct constants (FN_*) taken from InstrD[5:0]
//   - ctrl_e_t: packed Execute-stage control bundle
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_control;
  } ctrl_e_t;

  localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational main/ALU decoder.
//   instr_i    in  32  Decode-stage instruction
//   ctrl_o     out     Execute control bundle (bubble for illegal encodings)
//   illegal_o  out  1  instruction is not supported
//   branch_o   out  1  beq
//   jump_o     out  1  j
// Build option: ID_EX_CTRL_MULT_EN enables R-type MUL (funct 011000);
// without it that funct is treated as illegal.
module ctrl_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_e_t     ctrl_o,
  output logic        illegal_o,
  output logic        branch_o,
  output logic        jump_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign op    = instr_i[31:26];
  assign funct = instr_i[5:0];
  // Register/immediate fields play no part in control decode.
  assign unused_instr_bits = ^instr_i[25:6];

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl_o.alu_control = ALU_ADD;
          FN_SUB:  ctrl_o.alu_control = ALU_SUB;
          FN_AND:  ctrl_o.alu_control = ALU_AND;
          FN_OR:   ctrl_o.alu_control = ALU_OR;
          FN_SLT:  ctrl_o.alu_control = ALU_SLT;
`ifdef ID_EX_CTRL_MULT_EN
          FN_MUL:  ctrl_o.alu_control = ALU_MUL;
`endif
          default: begin
            ctrl_o    = CTRL_BUBBLE;
            illegal_o = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.mem_to_reg  = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_SW: begin
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        branch_o           = 1'b1;
        ctrl_o.alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = ALU_ADD;
      end
      OP_J: begin
        jump_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: control decoder fused with the ID/EX control pipeline register.
//   clk, reset          clock; asynchronous active-high reset
//   InstrD       in 32  Decode-stage instruction
//   StallE       in  1  hold E registers
//   FlushE       in  1  load a bubble (wins over StallE)
//   BranchD/JumpD out   combinational Decode flags
//   RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE[2:0]
//                 out   registered Execute controls
//   IllegalE     out 1  registered; set for an unsupported instruction
// Build option: ID_EX_CTRL_MULT_EN (see ctrl_decoder).
module id_ex_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic        BranchD,
  output logic        JumpD,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [2:0]  ALUControlE,
  output logic        IllegalE
);

  ctrl_e_t ctrl_dec;
  logic    illegal_dec;
  ctrl_e_t ctrl_d, ctrl_q;
  logic    illegal_d, illegal_q;

  ctrl_decoder u_dec (
    .instr_i   (InstrD),
    .ctrl_o    (ctrl_dec),
    .illegal_o (illegal_dec),
    .branch_o  (BranchD),
    .jump_o    (JumpD)
  );

  always_comb begin
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (FlushE) begin
      ctrl_d    = CTRL_BUBBLE;
      illegal_d = 1'b0;
    end else if (!StallE) begin
      ctrl_d    = ctrl_dec;
      illegal_d = illegal_dec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q    <= CTRL_BUBBLE;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemtoRegE   = ctrl_q.mem_to_reg;
  assign MemWriteE   = ctrl_q.mem_write;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign RegDstE     = ctrl_q.reg_dst;
  assign ALUControlE = ctrl_q.alu_control;
  assign IllegalE    = illegal_q;

endmodule

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Main/ALU control decoder fused with the ID/EX control pipeline register. It decodes the 32-bit instruction in Decode and produces the registered Execute-stage control bundle consumed downstream, including the 3-bit `ALUControlE` that drives the ALU. It also produces the combinational Decode-stage branch and jump flags. It supports hazard-unit stall and flush, and flags unsupported instructions.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-high.
- `InstrD`  in  32  — Decode-stage instruction; opcode = [31:26], funct = [5:0].
- `StallE`  in  1  — hold all E registers.
- `FlushE`  in  1  — load a bubble into E registers.
- `BranchD`  out  1  — combinational; 1 for beq.
- `JumpD`  out  1  — combinational; 1 for j.
- `RegWriteE`  out  1  — registered.
- `MemtoRegE`  out  1  — registered.
- `MemWriteE`  out  1  — registered.
- `ALUSrcE`  out  1  — registered; 1 selects the immediate.
- `RegDstE`  out  1  — registered; 1 selects rd.
- `ALUControlE`  out  3  — registered ALU operation.
- `IllegalE`  out  1  — registered; 1 for one cycle when an unsupported instruction was decoded.

## Operation
ALUControl encoding: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLT. Codes 011 and 111 are never produced.

Decode of `InstrD`:

- **R-type (op 000000):** RegWrite=1, RegDst=1, ALUSrc=0. ALU operation by funct:
  - 100000 → ADD
  - 100010 → SUB
  - 100100 → AND
  - 100101 → OR
  - 101010 → SLT
  - 011000 → MUL (see Configuration)
  - Any other funct is illegal.
- **lw (100011):** RegWrite=1, MemtoReg=1, ALUSrc=1, ADD.
- **sw (101011):** MemWrite=1, ALUSrc=1, ADD.
- **beq (000100):** BranchD=1, SUB.
- **addi (001000):** RegWrite=1, ALUSrc=1, ADD.
- **j (000010):** JumpD=1, all E controls 0.
- **Any other opcode:** illegal.

Illegal instructions:
- Decode to the bubble (all E controls 0, ALUControl=000).
- Set the next-state IllegalE=1.
- BranchD and JumpD stay 0.

`IllegalE` is 0 for every legal instruction, and for bubbles from flush or reset.

## Timing
- Reset: while `reset` is high, all registered outputs are 0 immediately and asynchronously. This includes `ALUControlE`=000 and `IllegalE`=0.
- `BranchD` and `JumpD` follow `InstrD` combinationally and are unaffected by reset, stall and flush.
- Latency: decoded controls appear on the E outputs 1 cycle after `InstrD` is sampled.
- Priority at each rising edge: `reset` > `FlushE` > `StallE` > load.
  - `FlushE`=1 loads the bubble (all 0), even if `StallE`=1 in the same cycle.
  - `StallE`=1 with `FlushE`=0 holds every E register, `IllegalE` included.
- `IllegalE` pulses for exactly one cycle per illegal instruction loaded. A stall extends it: the held value is repeated.
- Reset asserted mid-stream: outputs clear on assertion. The first load happens on the first rising edge after deassertion.

## Configuration
- `ID_EX_CTRL_MULT_EN` defined: R-type funct 011000 decodes to RegWrite=1, RegDst=1, ALUSrc=0, MUL (101). The product's low 32 bits are written to rd.
- `ID_EX_CTRL_MULT_EN` undefined: funct 011000 is illegal (bubble plus `IllegalE`), and ALUControl 101 is never produced.

## Structure
- Shared package `mips_pkg` holds:
  - the ALUControl encodings (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_MUL`, `ALU_SLT`);
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`);
  - funct constants;
  - a packed typedef `ctrl_e_t` for the E control bundle.
- One sub-module, `ctrl_decoder`: purely combinational. It maps `InstrD` to `ctrl_e_t`, plus the illegal flag, `BranchD` and `JumpD`.
- The top level contains the registers and the priority logic.

## Test plan
- Decode of add $t0,$t1,$t2: `InstrD`=0x012A4020 → next cycle RegWriteE=1, RegDstE=1, ALUSrcE=0, MemtoRegE=0, MemWriteE=0, ALUControlE=010, IllegalE=0.
- Decode of lw then beq:
  - lw, `InstrD`=0x8D280004 → next cycle ALUSrcE=1, MemtoRegE=1, RegWriteE=1, RegDstE=0, ALUControlE=010.
  - beq, `InstrD`=0x11090003 → BranchD=1 in the same cycle; next cycle ALUControlE=100, RegWriteE=0.
- Multiply: `InstrD`=0x012A0018.
  - With `ID_EX_CTRL_MULT_EN` → ALUControlE=101, RegWriteE=1.
  - Without → all E controls 0 and IllegalE=1 for one cycle.
- Hazard controls:
  - Load slt (0x012A402A), then assert `StallE` for 3 cycles while `InstrD` changes → ALUControlE stays 110.
  - Assert `FlushE` and `StallE` together → next cycle all E outputs 0.
- Reset mid-stream: assert `reset` between edges while ALUControlE=010 → outputs 0 immediately. After deassertion, the first edge loads the current `InstrD`.
- Illegal opcode: `InstrD`=0xFC000000 → bubble, IllegalE=1 for one cycle, then 0 when a legal instruction follows.
